// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants, sync polarity constants and the axis-total helper
// shared by the VGA timing generator and its axis counters.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CNT_W    = 11;
    localparam int DEF_FRAME_W  = 8;

    localparam logic POL_ACTIVE_LOW  = 1'b0;
    localparam logic POL_ACTIVE_HIGH = 1'b1;

    // Total positions on one axis (pixels per line or lines per frame).
    function automatic int axisTotal(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with sync and in-active flags decoded from
// the next count, so every flag is registered alongside the count it describes.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   ACTIVE = DEF_H_ACTIVE,
    parameter int   FP     = DEF_H_FP,
    parameter int   SYNC   = DEF_H_SYNC,
    parameter int   BP     = DEF_H_BP,
    parameter logic POL    = POL_ACTIVE_LOW,
    parameter int   CNT_W  = DEF_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             sync,
    output logic             inActive,
    output logic             wrap
);

    localparam int TOTAL = axisTotal(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);

    if (TOTAL > (1 << CNT_W)) begin : gTotalCheck
        $error("vga_axis_counter: axis total %0d does not fit in %0d bits", TOTAL, CNT_W);
    end
    if (FP == 0 || SYNC == 0 || BP == 0) begin : gZeroCheck
        $error("vga_axis_counter: porch and sync widths must be non-zero");
    end

    logic [CNT_W-1:0] nextCount;

    assign wrap = (count == LAST);

    always_comb begin
        nextCount = wrap ? '0 : count + CNT_W'(1);
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count    <= '0;
            sync     <= ~POL;
            inActive <= 1'b1;
        end else if (step) begin
            count    <= nextCount;
            sync     <= (nextCount >= SYNC_FIRST && nextCount <= SYNC_LAST) ? POL : ~POL;
            inActive <= (nextCount < ACT_END);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical counts, syncs, active flag and strobes.
// Define VGA_TIMING_FRAME_COUNT_EN to add the frameCount output and its counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic H_POL    = POL_ACTIVE_LOW,
    parameter logic V_POL    = POL_ACTIVE_LOW,
    parameter int   CNT_W    = DEF_CNT_W,
    parameter int   FRAME_W  = DEF_FRAME_W
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               pixEn,
    output logic [CNT_W-1:0]   hCount,
    output logic [CNT_W-1:0]   vCount,
    output logic               hSync,
    output logic               vSync,
    output logic               active,
    output logic               lineStart,
    output logic               frameStart
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    output logic [FRAME_W-1:0] frameCount
`endif
);

    if (FRAME_W < 1) begin : gFrameWCheck
        $error("vga_timing_gen: FRAME_W must be at least 1");
    end

    logic hWrap, vWrap, hInActive, vInActive;
    logic lineUpdate, frameUpdate;

    assign lineUpdate  = pixEn & hWrap;
    assign frameUpdate = lineUpdate & vWrap;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .CNT_W(CNT_W)
    ) uHAxis (
        .Clk(Clk), .Rst(Rst), .step(pixEn),
        .count(hCount), .sync(hSync), .inActive(hInActive), .wrap(hWrap)
    );

    // The vertical axis advances on the same update that wraps the horizontal one.
    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .CNT_W(CNT_W)
    ) uVAxis (
        .Clk(Clk), .Rst(Rst), .step(lineUpdate),
        .count(vCount), .sync(vSync), .inActive(vInActive), .wrap(vWrap)
    );

    assign active = hInActive & vInActive;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            lineStart  <= lineUpdate;
            frameStart <= frameUpdate;
        end
    end

`ifdef VGA_TIMING_FRAME_COUNT_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            frameCount <= '0;
        end else if (frameUpdate) begin
            frameCount <= frameCount + FRAME_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 line timing, a 320x240 high-polarity
// variant, and a tiny raster for whole frames, mid-sync reset and frameCount wrap.
module tb_vga_timing_gen;

    typedef struct packed {
        int   hAct; int hSs; int hSe; int hTot;
        int   vAct; int vSs; int vSe; int vTot;
        logic hPol; logic vPol;
    } cfg_t;

    typedef struct packed {
        int   h; int v; int frames;
        logic ls; logic fs;
    } mdl_t;

    localparam cfg_t CFG_A = '{640, 656, 751, 800, 480, 490, 491, 525, 1'b0, 1'b0};
    localparam cfg_t CFG_B = '{320, 336, 431, 480, 240, 250, 251, 285, 1'b1, 1'b1};
    localparam cfg_t CFG_C = '{8, 10, 12, 15, 6, 7, 8, 10, 1'b0, 1'b0};

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        rstA, rstB, rstC, pixEnA, pixEnB, pixEnC;
    logic [10:0] hCountA, vCountA, hCountB, vCountB, hCountC, vCountC;
    logic        hSyncA, vSyncA, activeA, lineStartA, frameStartA;
    logic        hSyncB, vSyncB, activeB, lineStartB, frameStartB;
    logic        hSyncC, vSyncC, activeC, lineStartC, frameStartC;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [7:0]  frameCountA, frameCountB, frameCountC;
`endif

    mdl_t mA, mB, mC;
    int   nCompared   = 0;
    int   nMismatched = 0;

    vga_timing_gen dutA (
        .Clk(Clk), .Rst(rstA), .pixEn(pixEnA), .hCount(hCountA), .vCount(vCountA),
        .hSync(hSyncA), .vSync(vSyncA), .active(activeA),
        .lineStart(lineStartA), .frameStart(frameStartA)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .frameCount(frameCountA)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(320), .V_ACTIVE(240), .H_POL(1'b1), .V_POL(1'b1)
    ) dutB (
        .Clk(Clk), .Rst(rstB), .pixEn(pixEnB), .hCount(hCountB), .vCount(vCountB),
        .hSync(hSyncB), .vSync(vSyncB), .active(activeB),
        .lineStart(lineStartB), .frameStart(frameStartB)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .frameCount(frameCountB)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dutC (
        .Clk(Clk), .Rst(rstC), .pixEn(pixEnC), .hCount(hCountC), .vCount(vCountC),
        .hSync(hSyncC), .vSync(vSyncC), .active(activeC),
        .lineStart(lineStartC), .frameStart(frameStartC)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .frameCount(frameCountC)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic advance(input cfg_t c, input logic en, inout mdl_t m);
        m.ls = 1'b0;
        m.fs = 1'b0;
        if (en) begin
            if (m.h == c.hTot - 1) begin
                m.h  = 0;
                m.ls = 1'b1;
                if (m.v == c.vTot - 1) begin
                    m.v      = 0;
                    m.fs     = 1'b1;
                    m.frames = (m.frames + 1) % 256;
                end else begin
                    m.v = m.v + 1;
                end
            end else begin
                m.h = m.h + 1;
            end
        end
    endtask

    task automatic checkOut(input string tag, input cfg_t c, input mdl_t m,
                            input logic [10:0] oh, input logic [10:0] ov,
                            input logic ohs, input logic ovs, input logic oact,
                            input logic ols, input logic ofs);
        logic expHs, expVs, expAct;
        expHs  = (m.h >= c.hSs && m.h <= c.hSe) ? c.hPol : ~c.hPol;
        expVs  = (m.v >= c.vSs && m.v <= c.vSe) ? c.vPol : ~c.vPol;
        expAct = (m.h < c.hAct) && (m.v < c.vAct);
        check({tag, ".hCount"},     32'(oh),   32'(m.h));
        check({tag, ".vCount"},     32'(ov),   32'(m.v));
        check({tag, ".hSync"},      32'(ohs),  32'(expHs));
        check({tag, ".vSync"},      32'(ovs),  32'(expVs));
        check({tag, ".active"},     32'(oact), 32'(expAct));
        check({tag, ".lineStart"},  32'(ols),  32'(m.ls));
        check({tag, ".frameStart"}, 32'(ofs),  32'(m.fs));
    endtask

    task automatic stepA(input logic en);
        pixEnA = en;
        @(posedge Clk); #1;
        advance(CFG_A, en, mA);
        checkOut("A", CFG_A, mA, hCountA, vCountA, hSyncA, vSyncA, activeA, lineStartA, frameStartA);
    endtask

    task automatic stepB(input logic en);
        pixEnB = en;
        @(posedge Clk); #1;
        advance(CFG_B, en, mB);
        checkOut("B", CFG_B, mB, hCountB, vCountB, hSyncB, vSyncB, activeB, lineStartB, frameStartB);
    endtask

    task automatic checkC();
        checkOut("C", CFG_C, mC, hCountC, vCountC, hSyncC, vSyncC, activeC, lineStartC, frameStartC);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        check("C.frameCount", 32'(frameCountC), 32'(mC.frames));
`endif
    endtask

    task automatic stepC(input logic en);
        pixEnC = en;
        @(posedge Clk); #1;
        advance(CFG_C, en, mC);
        checkC();
    endtask

    initial begin
        int lsSeen;
        int fsSeen;
        int seen255;
        rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
        pixEnA = 1'b0; pixEnB = 1'b0; pixEnC = 1'b0;
        mA = '0; mB = '0; mC = '0;

        // Reset state on all three configurations
        repeat (3) @(posedge Clk);
        #1;
        checkOut("A.rst", CFG_A, mA, hCountA, vCountA, hSyncA, vSyncA, activeA, lineStartA, frameStartA);
        checkOut("B.rst", CFG_B, mB, hCountB, vCountB, hSyncB, vSyncB, activeB, lineStartB, frameStartB);
        checkC();
        rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;

        // Default timing: idle hold, then one full line with pixEn held high
        stepA(1'b0);
        stepA(1'b0);
        lsSeen = 0;
        for (int i = 0; i < 800; i++) begin
            stepA(1'b1);
            if (lineStartA) lsSeen++;
        end
        pixEnA = 1'b0;
        check("A.lineWrapH", 32'(hCountA), 32'd0);
        check("A.lineWrapV", 32'(vCountA), 32'd1);
        check("A.lineStartCount", 32'(lsSeen), 32'd1);

        // Approach the next wrap, then advance only on one clock in four
        for (int i = 0; i < 795; i++) stepA(1'b1);
        lsSeen = 0;
        for (int i = 0; i < 40; i++) begin
            stepA((i % 4) == 0);
            if (lineStartA) lsSeen++;
        end
        pixEnA = 1'b0;
        check("A.sparseH", 32'(hCountA), 32'd5);
        check("A.sparseV", 32'(vCountA), 32'd2);
        check("A.sparseLineStarts", 32'(lsSeen), 32'd1);

        // 320x240 with active-high syncs: one line plus one pixel
        for (int i = 0; i < 481; i++) stepB(1'b1);
        pixEnB = 1'b0;
        check("B.wrapH", 32'(hCountB), 32'd1);
        check("B.wrapV", 32'(vCountB), 32'd1);

        // Tiny raster: two whole frames
        fsSeen = 0;
        for (int i = 0; i < 300; i++) begin
            stepC(1'b1);
            if (frameStartC) fsSeen++;
        end
        check("C.frameStarts", 32'(fsSeen), 32'd2);

        // Reset in the middle of both sync pulses (line 8, pixel 11)
        for (int i = 0; i < 131; i++) stepC(1'b1);
        check("C.midSyncH", 32'(hSyncC), 32'd0);
        check("C.midSyncV", 32'(vSyncC), 32'd0);
        #2 rstC = 1'b1;
        #1;
        mC = '0;
        checkC();
        @(posedge Clk); #1;
        checkC();
        rstC = 1'b0;
        stepC(1'b1);
        check("C.firstAfterReset", 32'(hCountC), 32'd1);

`ifdef VGA_TIMING_FRAME_COUNT_EN
        // 256 frames bring frameCount through 255 and back to 0
        seen255 = 0;
        for (int i = 0; i < 256 * 150; i++) begin
            stepC(1'b1);
            if (frameCountC == 8'd255) seen255 = 1;
        end
        check("C.frameCountWrap", 32'(frameCountC), 32'd0);
        check("C.frameCountMax", 32'(seen255), 32'd1);
`else
        seen255 = 0;
`endif

        // Hold with pixEn low: nothing moves, strobes stay low
        stepC(1'b0);
        stepC(1'b0);
        check("C.holdH", 32'(hCountC), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
